bch_encoder: RTL

- Systematic binary BCH encoder: the transmit-side counterpart of the team's BCH decoder.
- Supports the same three code selections: code 1 = (63,51) t=2, m=6; code 2 = (255,239) t=2, m=8; code 3 and code 0 = (1023,983) t=4, m=10.
- Accepts message bits 8 per cycle and emits codeword frames as 64-bit words of eight signed 8-bit BPSK symbols. These words drive the decoder's idata directly: highest position first, top byte = highest position.

---
 rtl/bch_pkg.sv | 123 ++++++++++++
 rtl/bch_lfsr8.sv | 40 ++++
 rtl/bch_encoder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bch_pkg.sv
// -----------------------------------------------------------------------------
// bch_pkg
// Shared definitions for the BCH encoder slice:
//   - code selection and FSM state enums
//   - frame geometry per code (N positions, P parity bits, MW message words)
//   - primitive polynomials and generator polynomials (G63 given, G255/G1023
//     derived at elaboration as the product of the minimal polynomials of
//     alpha, alpha^3 (and alpha^5, alpha^7 for t=4))
//   - BPSK symbol constants
// -----------------------------------------------------------------------------
package bch_pkg;

  typedef enum logic [1:0] {
    CODE_1023_ALT = 2'd0,
    CODE_63       = 2'd1,
    CODE_255      = 2'd2,
    CODE_1023     = 2'd3
  } code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSG  = 2'd1,
    ST_PAR  = 2'd2
  } state_e;

  // Remainder register width: parity count of the largest code.
  localparam int PMAX = 40;

  localparam logic [7:0] SYM_POS = 8'h7F;  // code bit 0
  localparam logic [7:0] SYM_NEG = 8'h81;  // code bit 1

  localparam logic [10:0] PRIM_63   = 11'h043;  // x^6+x+1
  localparam logic [10:0] PRIM_255  = 11'h11D;  // x^8+x^4+x^3+x^2+1
  localparam logic [10:0] PRIM_1023 = 11'h409;  // x^10+x^3+1

  // GF(2^m) multiply, m <= 10, prim includes the x^m term.
  function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b,
                                        input int m, input logic [10:0] prim);
    logic [10:0] aa;
    logic [9:0]  r;
    aa = {1'b0, a};
    r  = 10'd0;
    for (int i = 0; i < 10; i++) begin
      if (b[i]) r = r ^ aa[9:0];
      aa = aa << 1;
      if (aa[m]) aa = aa ^ prim;
    end
    return r;
  endfunction

  // Generator = product of minimal polynomials of alpha^1, alpha^3, ...,
  // alpha^(2t-1). Every coset involved has size m, so each minimal
  // polynomial is the product of (x + root^(2^k)) for k = 0..m-1.
  function automatic logic [40:0] gen_poly(input int m, input logic [10:0] prim, input int t);
    logic [40:0]       g;
    logic [40:0]       acc;
    logic [10:0][9:0]  c;
    logic [9:0]        root;
    g = 41'd1;
    for (int j = 1; j < 2 * t; j += 2) begin
      root = 10'd1;
      for (int i = 0; i < j; i++) root = gf_mul(root, 10'd2, m, prim);
      c    = '0;
      c[0] = 10'd1;
      for (int k = 0; k < m; k++) begin
        for (int i = 10; i > 0; i--) c[i] = c[i-1] ^ gf_mul(root, c[i], m, prim);
        c[0] = gf_mul(root, c[0], m, prim);
        root = gf_mul(root, root, m, prim);
      end
      // Minimal polynomial coefficients are 0/1; carry-less multiply into g.
      acc = 41'd0;
      for (int i = 0; i <= 10; i++) begin
        if (c[i][0]) acc = acc ^ (g << i);
      end
      g = acc;
    end
    return g;
  endfunction

  localparam logic [12:0] G63     = 13'h1539;
  localparam logic [40:0] G255_W  = gen_poly(8, PRIM_255, 2);
  localparam logic [16:0] G255    = G255_W[16:0];
  localparam logic [40:0] G1023   = gen_poly(10, PRIM_1023, 4);

  // Generators without the leading x^P term, left-aligned in PMAX bits so the
  // LFSR feedback tap is always the top bit regardless of code.
  localparam logic [PMAX-1:0] GL_63   = {G63[11:0], 28'd0};
  localparam logic [PMAX-1:0] GL_255  = {G255[15:0], 24'd0};
  localparam logic [PMAX-1:0] GL_1023 = G1023[39:0];

  function automatic logic [10:0] code_n(input code_e c);
    case (c)
      CODE_63:  return 11'd64;
      CODE_255: return 11'd256;
      default:  return 11'd1024;
    endcase
  endfunction

  function automatic logic [5:0] code_p(input code_e c);
    case (c)
      CODE_63:  return 6'd12;
      CODE_255: return 6'd16;
      default:  return 6'd40;
    endcase
  endfunction

  function automatic logic [6:0] code_mw(input code_e c);
    case (c)
      CODE_63:  return 7'd7;
      CODE_255: return 7'd30;
      default:  return 7'd123;
    endcase
  endfunction

  function automatic logic [PMAX-1:0] code_gen(input code_e c);
    case (c)
      CODE_63:  return GL_63;
      CODE_255: return GL_255;
      default:  return GL_1023;
    endcase
  endfunction

endpackage

// File: rtl/bch_lfsr8.sv
// -----------------------------------------------------------------------------
// bch_lfsr8
// Combinational 8-bit-parallel remainder update (x^P*m(x) mod g(x)).
// Bits are consumed MSB first; a bit whose mask is 0 is skipped entirely
// (no shift), so pad and parity positions do not disturb the remainder.
// Ports:
//   i_rem   current remainder, left-aligned (top bit = x^(P-1) coefficient)
//   i_gen   generator without leading term, left-aligned the same way
//   i_data  8 input bits, i_data[7] first
//   i_mask  per-bit enable
//   o_rem   updated remainder
// -----------------------------------------------------------------------------
module bch_lfsr8 #(
  parameter int W = 40
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_gen,
  input  logic [7:0]   i_data,
  input  logic [7:0]   i_mask,
  output logic [W-1:0] o_rem
);

  // Unrolled eight serial LFSR steps.
  always_comb begin : p_steps
    logic [W-1:0] r;
    logic         fb;
    r  = i_rem;
    fb = 1'b0;
    for (int b = 7; b >= 0; b--) begin
      if (i_mask[b]) begin
        fb = i_data[b] ^ r[W-1];
        r  = {r[W-2:0], 1'b0} ^ (fb ? i_gen : {W{1'b0}});
      end else begin
        fb = 1'b0;
      end
    end
    o_rem = r;
  end

endmodule

// File: rtl/bch_encoder.sv
// -----------------------------------------------------------------------------
// bch_encoder
// Systematic BCH encoder for (63,51), (255,239) and (1023,983) codes.
// Takes 8 message bits per cycle, emits each frame word one cycle later as
// eight BPSK symbols (highest position in the top byte).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   set, code     start pulse and code select (sampled in IDLE only)
//   in_valid      idata valid
//   in_ready      encoder accepts a message word this cycle
//   idata         message word, idata[7] = highest frame position
//   out_valid     odata valid
//   odata         eight symbols, odata[63:56] = highest position
//   finish        pulse with the last word of a frame
// -----------------------------------------------------------------------------
module bch_encoder
  import bch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic [1:0]  code,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  idata,
  output logic        out_valid,
  output logic [63:0] odata,
  output logic        finish
);

  state_e          r_state;
  state_e          w_next_state;
  code_e           r_code;
  logic [PMAX-1:0] r_rem;
  logic [6:0]      r_word;
  logic [63:0]     r_odata;
  logic            r_out_valid;
  logic            r_finish;

  logic [10:0]     w_n;
  logic [5:0]      w_p;
  logic [6:0]      w_mw;
  logic [6:0]      w_last;
  logic [PMAX-1:0] w_gen;
  logic [PMAX-1:0] w_lfsr_out;
  logic [7:0]      w_msg_mask;
  logic [7:0]      w_par_mask;
  logic [3:0]      w_npar;
  logic [63:0]     w_msg_sym;
  logic [63:0]     w_par_sym;
  logic            w_accept;
  logic            w_in_ready;

  assign w_n      = code_n(r_code);
  assign w_p      = code_p(r_code);
  assign w_mw     = code_mw(r_code);
  assign w_last   = 7'(w_n[10:3] - 8'd1);
  assign w_gen    = code_gen(r_code);
  assign w_accept = in_valid && w_in_ready;

  bch_lfsr8 #(.W(PMAX)) u_lfsr (
    .i_rem  (r_rem),
    .i_gen  (w_gen),
    .i_data (idata),
    .i_mask (w_msg_mask),
    .o_rem  (w_lfsr_out)
  );

  // Classify each bit of the current word and build its symbols.
  // Position of bit b in word w is N-8-8w+b.
  always_comb begin : p_word_map
    int   pos;
    int   idx;
    logic bit_v;
    pos        = 0;
    idx        = 0;
    bit_v      = 1'b0;
    w_msg_mask = 8'd0;
    w_par_mask = 8'd0;
    w_npar     = 4'd0;
    w_msg_sym  = 64'd0;
    w_par_sym  = 64'd0;
    for (int b = 0; b < 8; b++) begin
      pos = int'(w_n) - 8 - 8 * int'(r_word) + b;
      if (pos >= int'(w_p) && pos <= int'(w_n) - 2) begin
        w_msg_mask[b] = 1'b1;
      end else if (pos < int'(w_p)) begin
        w_par_mask[b] = 1'b1;
        w_npar        = w_npar + 4'd1;
      end else begin
        w_msg_mask[b] = 1'b0;
      end
      // Parity coefficient pos sits at bit PMAX-P+pos of the left-aligned remainder.
      idx = PMAX - int'(w_p) + pos;
      if (w_msg_mask[b]) begin
        bit_v = idata[b];
      end else if (w_par_mask[b]) begin
        bit_v = w_lfsr_out[idx];
      end else begin
        bit_v = 1'b0;
      end
      w_msg_sym[8*b +: 8] = bit_v ? SYM_NEG : SYM_POS;
      w_par_sym[8*b +: 8] = r_rem[PMAX-8+b] ? SYM_NEG : SYM_POS;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (set) w_next_state = ST_MSG;
        else     w_next_state = ST_IDLE;
      end
      ST_MSG: begin
        if (w_accept && (r_word == w_mw - 7'd1)) w_next_state = ST_PAR;
        else                                     w_next_state = ST_MSG;
      end
      ST_PAR: begin
        if (r_word == w_last) w_next_state = ST_IDLE;
        else                  w_next_state = ST_PAR;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_MSG:  w_in_ready = 1'b1;
      default: w_in_ready = 1'b0;
    endcase
  end

  // Datapath: code latch, remainder, word counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code      <= CODE_1023_ALT;
      r_rem       <= {PMAX{1'b0}};
      r_word      <= 7'd0;
      r_odata     <= 64'd0;
      r_out_valid <= 1'b0;
      r_finish    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_finish    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (set) begin
            r_code <= code_e'(code);
            r_rem  <= {PMAX{1'b0}};
            r_word <= 7'd0;
          end
        end
        ST_MSG: begin
          if (w_accept) begin
            // Parity bits already emitted in a mixed word are shifted out.
            r_rem       <= w_lfsr_out << w_npar;
            r_word      <= r_word + 7'd1;
            r_out_valid <= 1'b1;
            r_odata     <= w_msg_sym;
          end
        end
        ST_PAR: begin
          r_rem       <= r_rem << 6'd8;
          r_word      <= r_word + 7'd1;
          r_out_valid <= 1'b1;
          r_odata     <= w_par_sym;
          r_finish    <= (r_word == w_last);
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign odata     = r_odata;
  assign finish    = r_finish;

endmodule
